// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the segmented, pipelined add/subtract unit.
package pipe_adder_pkg;

  // Per-transaction mode bits. These travel with the data through every stage.
  typedef struct packed {
    logic sub;  // 1: A - B computed as A + ~B + 1
    logic sgn;  // two's-complement view for overflow and saturation
    logic sat;  // clamp the result when overflow is detected
  } mode_t;

  // Number of pipeline stages: one per SEG_BIT slice. The top slice may be narrower.
  function automatic int calc_num_stages(input int operand_bit, input int seg_bit);
    return (operand_bit + seg_bit - 1) / seg_bit;
  endfunction

  // Pattern builders for signed saturation: sign bit followed by fill bits.
  // Signed max is 0111..1 and signed min is 1000..0.
  localparam logic SAT_MAX_SIGN = 1'b0;
  localparam logic SAT_MAX_FILL = 1'b1;
  localparam logic SAT_MIN_SIGN = 1'b1;
  localparam logic SAT_MIN_FILL = 1'b0;

endpackage

// File: rtl/pipe_adder_seg.sv
// Combinational ripple segment: one SEG_W-wide slice of the wide add.
// Also reports the carry into its own MSB. The final stage uses that carry
// for signed overflow detection.
module pipe_adder_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SEG_W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  assign s    = sum[SEG_W-1:0];
  assign cout = sum[SEG_W];
  // The sum bit is a ^ b ^ carry-in, so the carry into the MSB can be recovered
  // from the sum bit and the two operand bits.
  assign c_msb_in = s[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit. Each stage adds one SEG_BIT slice, and the
// inter-slice carry is registered between stages. Operands skew forward with
// their transaction. The final stage applies overflow detection and optional
// saturation. All stages advance together under a single valid/ready
// handshake. The pipeline has no bubble collapsing.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int OPERAND_BIT = 10,
  parameter int SEG_BIT     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPERAND_BIT-1:0] in_a,
  input  logic [OPERAND_BIT-1:0] in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  input  logic                   in_signed,
  input  logic                   in_sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPERAND_BIT-1:0] out_s,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int NUM_STAGES = calc_num_stages(OPERAND_BIT, SEG_BIT);
  localparam int LAST_W     = OPERAND_BIT - (NUM_STAGES - 1) * SEG_BIT;
  localparam int REG_N      = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  // Global advance. When the output is held, every stage holds.
  logic adv;

  // Inter-stage registers. Entry k feeds stage k+1.
  logic                   stg_v_q [REG_N];
  logic [OPERAND_BIT-1:0] stg_a_q [REG_N];
  logic [OPERAND_BIT-1:0] stg_b_q [REG_N];
  logic [OPERAND_BIT-1:0] stg_s_q [REG_N];
  logic                   stg_c_q [REG_N];
  mode_t                  stg_m_q [REG_N];

  // Inputs seen by each stage. Stage 0 sees the ports; later stages see registers.
  logic                   st_v [NUM_STAGES];
  logic [OPERAND_BIT-1:0] st_a [NUM_STAGES];
  logic [OPERAND_BIT-1:0] st_b [NUM_STAGES];  // already inverted for subtract
  logic [OPERAND_BIT-1:0] st_s [NUM_STAGES];  // completed low slices of the sum
  logic                   st_c [NUM_STAGES];
  mode_t                  st_m [NUM_STAGES];

  // Results produced by each stage.
  logic [OPERAND_BIT-1:0] nx_s  [NUM_STAGES];
  logic                   nx_c  [NUM_STAGES];
  logic                   nx_cm [NUM_STAGES];

  // Output registers and their next-state values.
  logic                   out_valid_q;
  logic [OPERAND_BIT-1:0] out_s_q;
  logic [OPERAND_BIT-1:0] out_s_d;
  logic                   out_cout_q;
  logic                   out_ovf_q;
  logic                   out_ovf_d;

  // Final-stage view.
  mode_t                  fin_m;
  logic [OPERAND_BIT-1:0] fin_raw;
  logic                   fin_cout;
  logic                   fin_cmsb;
  logic                   fin_pos;
  logic [OPERAND_BIT-1:0] sat_val;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = k * SEG_BIT;
    localparam int W  = (k == NUM_STAGES - 1) ? LAST_W : SEG_BIT;

    logic [W-1:0]           seg_s;
    logic [OPERAND_BIT-1:0] s_mrg;

    if (k == 0) begin : g_src_port
      assign st_v[k] = in_valid;
      assign st_a[k] = in_a;
      assign st_b[k] = in_sub ? ~in_b : in_b;
      assign st_s[k] = '0;
      assign st_c[k] = in_sub ? 1'b1 : in_cin;
      assign st_m[k] = mode_t'{sub: in_sub, sgn: in_signed, sat: in_sat};
    end else begin : g_src_reg
      assign st_v[k] = stg_v_q[k-1];
      assign st_a[k] = stg_a_q[k-1];
      assign st_b[k] = stg_b_q[k-1];
      assign st_s[k] = stg_s_q[k-1];
      assign st_c[k] = stg_c_q[k-1];
      assign st_m[k] = stg_m_q[k-1];
    end

    pipe_adder_seg #(
      .SEG_W(W)
    ) u_seg (
      .a       (st_a[k][LO +: W]),
      .b       (st_b[k][LO +: W]),
      .cin     (st_c[k]),
      .s       (seg_s),
      .cout    (nx_c[k]),
      .c_msb_in(nx_cm[k])
    );

    // Splice this stage's slice into the partial sum carried by the transaction.
    always_comb begin
      // NOTE: give every combinational output a full default first so that no
      // path leaves it unassigned and a latch is inferred.
      s_mrg            = st_s[k];
      s_mrg[LO +: W]   = seg_s;
    end

    assign nx_s[k] = s_mrg;

    if (k < NUM_STAGES - 1) begin : g_reg
      // Stage valid bit: cleared on reset so in-flight data is discarded.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register sees
        // pre-edge values; blocking (=) is reserved for combinational blocks.
        if (!rst_n) begin
          stg_v_q[k] <= 1'b0;
        end else if (adv) begin
          stg_v_q[k] <= st_v[k];
        end
      end

      // Stage payload: operands, partial sum, carry and mode move forward on advance.
      // NOTE: payload registers have no reset. Their contents are ignored
      // while the matching valid bit is 0, so a reset net here is wasted.
      always_ff @(posedge clk) begin
        if (adv) begin
          stg_a_q[k] <= st_a[k];
          stg_b_q[k] <= st_b[k];
          stg_s_q[k] <= s_mrg;
          stg_c_q[k] <= nx_c[k];
          stg_m_q[k] <= st_m[k];
        end
      end
    end
  end

  assign fin_m    = st_m[NUM_STAGES-1];
  assign fin_raw  = nx_s[NUM_STAGES-1];
  assign fin_cout = nx_c[NUM_STAGES-1];
  assign fin_cmsb = nx_cm[NUM_STAGES-1];
  // Signed overflow only occurs when A and B' share a sign, so A's sign alone
  // gives the overflow direction.
  assign fin_pos  = !st_a[NUM_STAGES-1][OPERAND_BIT-1];

  // Overflow under the selected mode, and the value to clamp to.
  always_comb begin
    if (fin_m.sgn) begin
      out_ovf_d = fin_cmsb ^ fin_cout;
      sat_val   = fin_pos ? {SAT_MAX_SIGN, {(OPERAND_BIT-1){SAT_MAX_FILL}}}
                          : {SAT_MIN_SIGN, {(OPERAND_BIT-1){SAT_MIN_FILL}}};
    end else if (fin_m.sub) begin
      out_ovf_d = !fin_cout;  // no carry out means a borrow occurred
      sat_val   = '0;
    end else begin
      out_ovf_d = fin_cout;
      sat_val   = '1;
    end
    out_s_d = (fin_m.sat && out_ovf_d) ? sat_val : fin_raw;
  end

  // Output registers: load on advance, hold steady while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= st_v[NUM_STAGES-1];
      if (st_v[NUM_STAGES-1]) begin
        out_s_q    <= out_s_d;
        out_cout_q <= fin_cout;
        out_ovf_q  <= out_ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder with OPERAND_BIT=10 and SEG_BIT=4 (3 stages).
// A plain-arithmetic reference model fills a scoreboard at every accepted input.
// A single compare process checks each output handshake against it. Directed
// cases also pin hand-computed values and latency.
module tb_pipe_adder;

  localparam int OB   = 10;
  localparam int SB   = 4;
  localparam int LAT  = 3;
  localparam int MAXS = (1 << (OB - 1)) - 1;
  localparam int MINS = -(1 << (OB - 1));

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [OB-1:0] in_a;
  logic [OB-1:0] in_b;
  logic          in_cin;
  logic          in_sub;
  logic          in_signed;
  logic          in_sat;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_s;
  logic          out_cout;
  logic          out_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  bit chk_en   = 0;

  logic [OB+1:0] exp_q [$];  // {ovf, cout, s}

  bit            hold_pend = 0;
  logic [OB+1:0] hold_val;

  pipe_adder #(
    .OPERAND_BIT(OB),
    .SEG_BIT    (SB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .in_signed(in_signed),
    .in_sat   (in_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model built from integer arithmetic. Returns {ovf, cout, s}.
  function automatic logic [OB+1:0] model(input logic [OB-1:0] a, input logic [OB-1:0] b,
                                          input logic cin, input logic sub,
                                          input logic sgn, input logic sat);
    logic [OB-1:0] bn;
    int            c0, full, sa, sbn, tot, s;
    logic          cout, ovf;
    bn   = sub ? ~b : b;
    c0   = sub ? 1 : int'(cin);
    full = int'(a) + int'(bn) + c0;
    cout = (full >= (1 << OB));
    s    = full % (1 << OB);
    sa   = int'(a)  - (a[OB-1]  ? (1 << OB) : 0);
    sbn  = int'(bn) - (bn[OB-1] ? (1 << OB) : 0);
    tot  = sa + sbn + c0;
    if (sgn) ovf = (tot > MAXS) || (tot < MINS);
    else     ovf = sub ? !cout : cout;
    if (sat && ovf) begin
      if (sgn) s = (tot > 0) ? MAXS : (1 << (OB - 1));
      else     s = sub ? 0 : (1 << OB) - 1;
    end
    return {ovf, cout, s[OB-1:0]};
  endfunction

  // Compare process: handshake rule, stall hold, scoreboard pop and model push.
  always @(negedge clk) begin
    logic [OB+1:0] e;
    if (chk_en) begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold_pend) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", {out_ovf, out_cout, out_s}, hold_val);
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_ovf, out_cout, out_s};
      if (out_valid && out_ready) begin
        n_out++;
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_s", out_s, e[OB-1:0]);
          check("out_cout", out_cout, e[OB]);
          check("out_ovf", out_ovf, e[OB+1]);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_a, in_b, in_cin, in_sub, in_signed, in_sat));
    end else begin
      hold_pend = 0;
    end
  end

  task automatic set_in(input logic [OB-1:0] a, input logic [OB-1:0] b,
                        input logic cin, input logic sub, input logic sgn, input logic sat);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_signed = sgn; in_sat = sat;
  endtask

  // One isolated transaction. Checks latency and hand-computed outputs.
  task automatic drive_one(input string name,
                           input logic [OB-1:0] a, input logic [OB-1:0] b,
                           input logic cin, input logic sub, input logic sgn, input logic sat,
                           input logic [OB-1:0] es, input logic ec, input logic eo);
    bit acc, seen;
    int lat;
    @(posedge clk); #1;
    set_in(a, b, cin, sub, sgn, sat);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
    end
    check({name, "_accepted"}, acc, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        lat  = i;
      end
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_latency"}, lat, LAT);
    check({name, "_s"}, out_s, es);
    check({name, "_cout"}, out_cout, ec);
    check({name, "_ovf"}, out_ovf, eo);
  endtask

  logic [OB-1:0] va [6];
  logic [OB-1:0] vb [6];
  logic [3:0]    vm [6];  // {cin, sub, sgn, sat}

  initial begin
    int idx;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_in('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_s", out_s, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;

    // Directed vectors with hand-computed results
    drive_one("add_300_200",   10'd300,  10'd200, 0, 0, 0, 0, 10'd500,  0, 0);
    drive_one("add_1000_100",  10'd1000, 10'd100, 0, 0, 0, 0, 10'd76,   1, 1);
    drive_one("add_1000_sat",  10'd1000, 10'd100, 0, 0, 0, 1, 10'd1023, 1, 1);
    drive_one("sadd_500_100",  10'd500,  10'd100, 0, 0, 1, 0, 10'h258,  0, 1);
    drive_one("sadd_500_sat",  10'd500,  10'd100, 0, 0, 1, 1, 10'd511,  0, 1);
    drive_one("sadd_neg_sat",  10'd524,  10'd924, 0, 0, 1, 1, 10'h200,  1, 1);
    drive_one("sub_5_7",       10'd5,    10'd7,   0, 1, 0, 0, 10'd1022, 0, 1);
    drive_one("sub_5_7_sat",   10'd5,    10'd7,   0, 1, 0, 1, 10'd0,    0, 1);
    drive_one("ssub_5_7",      10'd5,    10'd7,   0, 1, 1, 0, 10'd1022, 0, 0);
    drive_one("add_cin",       10'd7,    10'd8,   1, 0, 0, 0, 10'd16,   0, 0);
    drive_one("sub_cin_ign",   10'd7,    10'd5,   1, 1, 0, 0, 10'd2,    1, 0);
    drive_one("ssub_min_sat",  10'd512,  10'd1,   0, 1, 1, 1, 10'h200,  1, 1);

    // Back-to-back stream with a two-cycle downstream stall
    va[0] = 10'd300;  vb[0] = 10'd200; vm[0] = 4'b0000;
    va[1] = 10'd1000; vb[1] = 10'd100; vm[1] = 4'b0001;
    va[2] = 10'd500;  vb[2] = 10'd100; vm[2] = 4'b0011;
    va[3] = 10'd524;  vb[3] = 10'd924; vm[3] = 4'b0011;
    va[4] = 10'd5;    vb[4] = 10'd7;   vm[4] = 4'b0100;
    va[5] = 10'd123;  vb[5] = 10'd45;  vm[5] = 4'b1000;
    @(posedge clk); #1;
    n_out = 0;
    idx   = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      out_ready = !(c == 4 || c == 5);
      in_valid  = (idx < 6);
      if (idx < 6) set_in(va[idx], vb[idx], vm[idx][3], vm[idx][2], vm[idx][1], vm[idx][0]);
      @(negedge clk);
      if (c == 4 || c == 5) check("stream_stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", idx, 6);
    check("stream_outputs", n_out, 6);
    check("stream_queue_empty", exp_q.size(), 0);

    // Reset with two transactions in flight
    set_in(10'd11, 10'd22, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(10'd33, 10'd44, 0, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_out_valid", out_valid, 1);
    chk_en = 0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    n_out  = 0;
    chk_en = 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("post_reset_no_stale", n_out, 0);
    check("post_reset_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
